// File: rtl/deck_shuffler.sv
// deck_shuffler: builds a multi-deck card array, Fisher-Yates shuffles it
// in place from a seeded Galois LFSR, then deals it over valid/ready.
module deck_shuffler #(
  parameter  int NUM_RANKS = 13,
  parameter  int NUM_SUITS = 4,
  parameter  int NUM_DECKS = 1,
  localparam int N         = NUM_DECKS * NUM_RANKS * NUM_SUITS,
  localparam int IDX_W     = $clog2(N),
  localparam int CNT_W     = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      seed,
  output logic [6:0]       card_out,
  output logic             card_valid,
  input  logic             card_ready,
  output logic [CNT_W-1:0] cards_left,
  output logic             busy,
  output logic             empty
);

  typedef enum logic [2:0] {
    IDLE,
    BUILD,
    SHUFFLE,
    DEAL,
    DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST      = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] ONE       = IDX_W'(1);
  localparam logic [15:0]      SEED_DEF  = 16'hACE1;
  localparam logic [15:0]      TAPS      = 16'hB400;
  localparam logic [1:0]       SUIT_LAST = 2'(NUM_SUITS - 1);
  localparam logic [3:0]       RANK_LAST = 4'(NUM_RANKS);

  state_t           state;
  state_t           state_nxt;
  logic [6:0]       mem [N];
  logic [15:0]      lfsr;
  logic [15:0]      lfsr_nxt;
  logic [15:0]      seed_eff;
  logic [IDX_W-1:0] k;
  logic [IDX_W-1:0] i;
  logic [IDX_W-1:0] j;
  logic [IDX_W-1:0] deal_idx;
  logic [3:0]       b_rank;
  logic [1:0]       b_suit;
  logic [31:0]      prod;
  logic             fire;
  logic             unused_prod;

  // A zero seed would lock the LFSR, so it falls back to the default.
  assign seed_eff = (seed == 16'h0) ? SEED_DEF : seed;
  assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0);

  // Scale the fresh LFSR word into 0..i with a multiply-high.
  assign prod = 32'(lfsr_nxt) * (32'(i) + 32'd1);
  assign j    = prod[16 +: IDX_W];
  assign unused_prod = ^{prod[31:16+IDX_W], prod[15:0]};

  assign card_valid = (state == DEAL);
  assign card_out   = card_valid ? mem[deal_idx] : 7'h0;
  assign fire       = card_valid & card_ready;
  assign busy       = (state == BUILD) | (state == SHUFFLE);
  assign empty      = (state == IDLE) | (state == DONE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; start only matters when idle, done or dealing.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (start) state_nxt = BUILD;
      BUILD:      if (k == LAST) state_nxt = SHUFFLE;
      SHUFFLE:    if (i == ONE) state_nxt = DEAL;
      DEAL: begin
        if (start)
          state_nxt = BUILD;
        else if (fire && cards_left == CNT_W'(1))
          state_nxt = DONE;
      end
      default:    state_nxt = IDLE;
    endcase
  end

  // Counters, LFSR and builder rank/suit walk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr       <= SEED_DEF;
      k          <= '0;
      i          <= '0;
      deal_idx   <= '0;
      cards_left <= '0;
      b_rank     <= 4'd1;
      b_suit     <= 2'd0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            lfsr   <= seed_eff;
            k      <= '0;
            b_rank <= 4'd1;
            b_suit <= 2'd0;
          end
        end
        BUILD: begin
          k <= k + 1'b1;
          if (b_suit == SUIT_LAST) begin
            b_suit <= 2'd0;
            b_rank <= (b_rank == RANK_LAST) ? 4'd1 : b_rank + 4'd1;
          end else begin
            b_suit <= b_suit + 2'd1;
          end
          if (k == LAST) i <= LAST;
        end
        SHUFFLE: begin
          lfsr <= lfsr_nxt;
          i    <= i - 1'b1;
          if (i == ONE) begin
            deal_idx   <= '0;
            cards_left <= CNT_W'(N);
          end
        end
        DEAL: begin
          if (fire) begin
            deal_idx   <= deal_idx + 1'b1;
            cards_left <= cards_left - 1'b1;
          end
          if (start) begin
            lfsr       <= seed_eff;
            k          <= '0;
            b_rank     <= 4'd1;
            b_suit     <= 2'd0;
            deal_idx   <= '0;
            cards_left <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Card array: sequential build writes, then one swap per shuffle step.
  always_ff @(posedge clk) begin
    if (state == BUILD) begin
      mem[k] <= {b_rank, b_suit, 1'b0};
    end else if (state == SHUFFLE) begin
      mem[i] <= mem[j];
      mem[j] <= mem[i];
    end
  end

endmodule

// File: tb/tb_deck_shuffler.sv
// tb_deck_shuffler: directed checks of build/shuffle/deal timing, ordering,
// restart, reset and multi-deck behaviour across three configurations.
module tb_deck_shuffler;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic        a_start = 1'b0;
  logic [15:0] a_seed  = 16'h0;
  logic        a_ready = 1'b0;
  logic [6:0]  a_card;
  logic        a_valid;
  logic [5:0]  a_left;
  logic        a_busy;
  logic        a_empty;

  logic        b_start = 1'b0;
  logic [15:0] b_seed  = 16'h0;
  logic        b_ready = 1'b0;
  logic [6:0]  b_card;
  logic        b_valid;
  logic [1:0]  b_left;
  logic        b_busy;
  logic        b_empty;

  logic        c_start = 1'b0;
  logic [15:0] c_seed  = 16'h0;
  logic        c_ready = 1'b0;
  logic [6:0]  c_card;
  logic        c_valid;
  logic [6:0]  c_left;
  logic        c_busy;
  logic        c_empty;

  deck_shuffler u_a (
    .clk(clk), .rst(rst), .start(a_start), .seed(a_seed),
    .card_out(a_card), .card_valid(a_valid), .card_ready(a_ready),
    .cards_left(a_left), .busy(a_busy), .empty(a_empty)
  );

  deck_shuffler #(.NUM_RANKS(1), .NUM_SUITS(2), .NUM_DECKS(1)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .seed(b_seed),
    .card_out(b_card), .card_valid(b_valid), .card_ready(b_ready),
    .cards_left(b_left), .busy(b_busy), .empty(b_empty)
  );

  deck_shuffler #(.NUM_RANKS(13), .NUM_SUITS(4), .NUM_DECKS(2)) u_c (
    .clk(clk), .rst(rst), .start(c_start), .seed(c_seed),
    .card_out(c_card), .card_valid(c_valid), .card_ready(c_ready),
    .cards_left(c_left), .busy(c_busy), .empty(c_empty)
  );

  int checks   = 0;
  int failures = 0;
  int got_q[$];
  int exp_q[$];
  int ref_q[$];
  bit stall_bad;
  bit left_bad;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference Fisher-Yates on the ordered deck.
  task automatic build_model(input int nd, input int nr, input int ns,
                             input logic [15:0] sd);
    int m[];
    int n;
    int j;
    int t;
    logic [15:0] l;
    n = nd * nr * ns;
    m = new[n];
    for (int d = 0; d < nd; d++)
      for (int r = 1; r <= nr; r++)
        for (int s = 0; s < ns; s++)
          m[d*nr*ns + (r-1)*ns + s] = r * 8 + s * 2;
    l = (sd == 16'h0) ? 16'hACE1 : sd;
    for (int i = n - 1; i >= 1; i--) begin
      l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0);
      j = int'((longint'(l) * longint'(i + 1)) >> 16);
      t = m[i];
      m[i] = m[j];
      m[j] = t;
    end
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back(m[k]);
  endtask

  function automatic int q_diff(input int x[$], input int y[$]);
    int d;
    d = 0;
    if (x.size() != y.size()) return 1000 + x.size();
    for (int k = 0; k < x.size(); k++)
      if (x[k] != y[k]) d++;
    return d;
  endfunction

  task automatic a_go(input logic [15:0] sd);
    a_seed  = sd;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  task automatic a_wait_valid(output int edges);
    edges = 0;
    while (!a_valid && edges < 400) begin
      tick();
      edges++;
    end
  endtask

  task automatic a_deal(input int duty);
    int cyc;
    bit have;
    bit r;
    logic [6:0] prev;
    cyc  = 0;
    have = 1'b0;
    prev = 7'h0;
    got_q.delete();
    stall_bad = 1'b0;
    left_bad  = 1'b0;
    while (got_q.size() < 52 && cyc < 3000) begin
      r = ($urandom_range(99) < duty);
      a_ready = r;
      if (a_valid) begin
        if (a_left != 6'(52 - got_q.size())) left_bad = 1'b1;
        if (have && a_card != prev) stall_bad = 1'b1;
        if (r) begin
          got_q.push_back(int'(a_card));
          have = 1'b0;
        end else begin
          prev = a_card;
          have = 1'b1;
        end
      end
      tick();
      cyc++;
    end
    a_ready = 1'b0;
  endtask

  task automatic test_reset;
    bit bad;
    bad = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (a_empty !== 1'b1 || a_valid !== 1'b0 || a_busy !== 1'b0 ||
          a_left !== 6'd0 || b_empty !== 1'b1 || c_empty !== 1'b1)
        bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL reset_idle_hold got=changed exp=held");
    end
    checks++;
    if (a_card !== 7'h0) begin
      failures++;
      $display("FAIL reset_card got=%h exp=00", a_card);
    end
    checks++;
    if (a_left !== 6'd0) begin
      failures++;
      $display("FAIL reset_left got=%0d exp=0", a_left);
    end
  endtask

  task automatic test_two_card;
    int e;
    b_seed  = 16'hACE1;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    checks++;
    if (b_busy !== 1'b1) begin
      failures++;
      $display("FAIL n2_busy got=%b exp=1", b_busy);
    end
    e = 0;
    while (!b_valid && e < 50) begin
      tick();
      e++;
    end
    checks++;
    if (e !== 3) begin
      failures++;
      $display("FAIL n2_latency got=%0d exp=3", e);
    end
    checks++;
    if (b_card !== 7'h08 || b_left !== 2'd2) begin
      failures++;
      $display("FAIL n2_card0 got=%h/%0d exp=08/2", b_card, b_left);
    end
    b_ready = 1'b1;
    tick();
    checks++;
    if (b_card !== 7'h0A || b_valid !== 1'b1 || b_left !== 2'd1) begin
      failures++;
      $display("FAIL n2_card1 got=%h/%b/%0d exp=0a/1/1",
               b_card, b_valid, b_left);
    end
    tick();
    b_ready = 1'b0;
    checks++;
    if (b_valid !== 1'b0 || b_empty !== 1'b1 || b_left !== 2'd0 ||
        b_card !== 7'h0) begin
      failures++;
      $display("FAIL n2_done got=%b/%b/%0d/%h exp=0/1/0/00",
               b_valid, b_empty, b_left, b_card);
    end
  endtask

  task automatic test_deal_52;
    bit bad;
    int cnt[128];
    int last;
    bad = 1'b0;
    a_go(16'hACE1);
    for (int e = 1; e <= 102; e++) begin
      if (a_busy !== 1'b1 || a_valid !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad || a_busy !== 1'b1) begin
      failures++;
      $display("FAIL d52_busy_window got=bad exp=busy_no_valid");
    end
    tick();
    checks++;
    if (a_valid !== 1'b1 || a_busy !== 1'b0 || a_left !== 6'd52 ||
        a_empty !== 1'b0) begin
      failures++;
      $display("FAIL d52_first_valid got=%b/%b/%0d/%b exp=1/0/52/0",
               a_valid, a_busy, a_left, a_empty);
    end
    a_deal(100);
    build_model(1, 13, 4, 16'hACE1);
    checks++;
    if (q_diff(got_q, exp_q) != 0) begin
      failures++;
      $display("FAIL d52_sequence got=%0d_diffs exp=0", q_diff(got_q, exp_q));
    end
    last = (got_q.size() == 52) ? got_q[51] : -1;
    checks++;
    if (last != 'h62) begin
      failures++;
      $display("FAIL d52_last_card got=%h exp=62", last);
    end
    for (int k = 0; k < 128; k++) cnt[k] = 0;
    foreach (got_q[k]) cnt[got_q[k] & 127]++;
    bad = 1'b0;
    for (int r = 1; r <= 13; r++)
      for (int s = 0; s < 4; s++)
        if (cnt[r*8 + s*2] != 1) bad = 1'b1;
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL d52_permutation got=dup_or_missing exp=each_once");
    end
    checks++;
    if (left_bad) begin
      failures++;
      $display("FAIL d52_cards_left got=wrong exp=52_minus_dealt");
    end
    checks++;
    if (a_valid !== 1'b0 || a_empty !== 1'b1 || a_left !== 6'd0) begin
      failures++;
      $display("FAIL d52_done got=%b/%b/%0d exp=0/1/0",
               a_valid, a_empty, a_left);
    end
    ref_q = got_q;
  endtask

  task automatic test_determinism;
    int e;
    a_go(16'h0000);
    a_wait_valid(e);
    checks++;
    if (e !== 103) begin
      failures++;
      $display("FAIL det_latency got=%0d exp=103", e);
    end
    a_deal(100);
    checks++;
    if (q_diff(got_q, ref_q) != 0) begin
      failures++;
      $display("FAIL det_seed0 got=%0d_diffs exp=0", q_diff(got_q, ref_q));
    end
    a_go(16'h1234);
    a_wait_valid(e);
    a_deal(100);
    build_model(1, 13, 4, 16'h1234);
    checks++;
    if (q_diff(got_q, exp_q) != 0) begin
      failures++;
      $display("FAIL det_seed1234 got=%0d_diffs exp=0", q_diff(got_q, exp_q));
    end
    checks++;
    if (q_diff(got_q, ref_q) == 0) begin
      failures++;
      $display("FAIL det_distinct got=same exp=different");
    end
  endtask

  task automatic test_backpressure;
    int e;
    a_go(16'hACE1);
    a_wait_valid(e);
    a_deal(30);
    checks++;
    if (stall_bad) begin
      failures++;
      $display("FAIL bp_stable got=changed exp=stable");
    end
    checks++;
    if (left_bad) begin
      failures++;
      $display("FAIL bp_cards_left got=wrong exp=handshake_only");
    end
    checks++;
    if (q_diff(got_q, ref_q) != 0) begin
      failures++;
      $display("FAIL bp_sequence got=%0d_diffs exp=0", q_diff(got_q, ref_q));
    end
  endtask

  task automatic test_restart;
    int e;
    a_go(16'hACE1);
    a_wait_valid(e);
    a_ready = 1'b1;
    repeat (10) tick();
    checks++;
    if (a_card !== 7'(ref_q[10]) || a_left !== 6'd42) begin
      failures++;
      $display("FAIL rs_card10 got=%h/%0d exp=%h/42", a_card, a_left, ref_q[10]);
    end
    a_seed  = 16'h1234;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    a_ready = 1'b0;
    checks++;
    if (a_busy !== 1'b1 || a_valid !== 1'b0 || a_left !== 6'd0) begin
      failures++;
      $display("FAIL rs_rebuild got=%b/%b/%0d exp=1/0/0",
               a_busy, a_valid, a_left);
    end
    a_wait_valid(e);
    checks++;
    if (e !== 103 || a_left !== 6'd52) begin
      failures++;
      $display("FAIL rs_latency got=%0d/%0d exp=103/52", e, a_left);
    end
    a_deal(100);
    build_model(1, 13, 4, 16'h1234);
    checks++;
    if (q_diff(got_q, exp_q) != 0) begin
      failures++;
      $display("FAIL rs_sequence got=%0d_diffs exp=0", q_diff(got_q, exp_q));
    end
  endtask

  task automatic test_start_in_shuffle;
    int e;
    a_go(16'hACE1);
    repeat (60) tick();
    a_seed  = 16'h1234;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    checks++;
    if (a_busy !== 1'b1) begin
      failures++;
      $display("FAIL ss_busy got=%b exp=1", a_busy);
    end
    a_wait_valid(e);
    checks++;
    if (e !== 42) begin
      failures++;
      $display("FAIL ss_latency got=%0d exp=42", e);
    end
    a_deal(100);
    checks++;
    if (q_diff(got_q, ref_q) != 0) begin
      failures++;
      $display("FAIL ss_sequence got=%0d_diffs exp=0", q_diff(got_q, ref_q));
    end
  endtask

  task automatic test_rst_mid;
    int e;
    a_go(16'hACE1);
    repeat (70) tick();
    checks++;
    if (a_busy !== 1'b1) begin
      failures++;
      $display("FAIL rm_pre_busy got=%b exp=1", a_busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (a_busy !== 1'b0 || a_empty !== 1'b1 || a_valid !== 1'b0 ||
        a_left !== 6'd0) begin
      failures++;
      $display("FAIL rm_shuffle got=%b/%b/%b/%0d exp=0/1/0/0",
               a_busy, a_empty, a_valid, a_left);
    end
    rst = 1'b0;
    repeat (5) tick();
    checks++;
    if (a_empty !== 1'b1 || a_valid !== 1'b0) begin
      failures++;
      $display("FAIL rm_stays_idle got=%b/%b exp=1/0", a_empty, a_valid);
    end
    a_go(16'hACE1);
    a_wait_valid(e);
    a_ready = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    checks++;
    if (a_valid !== 1'b0 || a_left !== 6'd0 || a_card !== 7'h0) begin
      failures++;
      $display("FAIL rm_deal got=%b/%0d/%h exp=0/0/00", a_valid, a_left, a_card);
    end
    a_ready = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_two_decks;
    int e;
    int cyc;
    int cnt[128];
    bit bad;
    c_seed  = 16'h5A5A;
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    e = 0;
    while (!c_valid && e < 400) begin
      tick();
      e++;
    end
    checks++;
    if (e !== 207 || c_left !== 7'd104) begin
      failures++;
      $display("FAIL dd_latency got=%0d/%0d exp=207/104", e, c_left);
    end
    got_q.delete();
    c_ready = 1'b1;
    cyc = 0;
    while (got_q.size() < 104 && cyc < 500) begin
      if (c_valid) got_q.push_back(int'(c_card));
      tick();
      cyc++;
    end
    c_ready = 1'b0;
    build_model(2, 13, 4, 16'h5A5A);
    checks++;
    if (q_diff(got_q, exp_q) != 0) begin
      failures++;
      $display("FAIL dd_sequence got=%0d_diffs exp=0", q_diff(got_q, exp_q));
    end
    for (int k = 0; k < 128; k++) cnt[k] = 0;
    foreach (got_q[k]) cnt[got_q[k] & 127]++;
    bad = 1'b0;
    for (int r = 1; r <= 13; r++)
      for (int s = 0; s < 4; s++)
        if (cnt[r*8 + s*2] != 2) bad = 1'b1;
    checks++;
    if (bad || got_q.size() != 104) begin
      failures++;
      $display("FAIL dd_twice got=%0d_cards_bad=%b exp=104_each_twice",
               got_q.size(), bad);
    end
    checks++;
    if (c_empty !== 1'b1 || c_valid !== 1'b0) begin
      failures++;
      $display("FAIL dd_done got=%b/%b exp=1/0", c_empty, c_valid);
    end
  endtask

  initial begin
    test_reset();
    test_two_card();
    test_deal_52();
    test_determinism();
    test_backpressure();
    test_restart();
    test_start_in_shuffle();
    test_rst_mid();
    test_two_decks();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
